// File: rtl/secure_serdes_pkg.sv
// -----------------------------------------------------------------------------
// secure_serdes_pkg
// Shared definitions for the secure SerDes link (receive side and encryptor):
//   - state_e     : receive FSM states (IDLE, RECV, DECRYPT)
//   - FRAME_BITS  : bits per serial frame
//   - DEFAULT_KEY : 128-bit shared link key
//   - key_byte_at : selects byte idx of a 128-bit key (byte 0 = key[7:0])
// -----------------------------------------------------------------------------
package secure_serdes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DECRYPT = 2'd2
  } state_e;

  localparam int FRAME_BITS = 8;

  localparam logic [127:0] DEFAULT_KEY = 128'hA1B2_C3D4_E5F6_0123_4567_89AB_CDEF_1234;

  function automatic logic [7:0] key_byte_at(input logic [127:0] key, input logic [3:0] idx);
    return key[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/secure_serdes_shift_in.sv
// -----------------------------------------------------------------------------
// secure_serdes_shift_in
// Serial-in / parallel-out shift register, MSB first (new bits enter at bit 0).
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset (clears the register)
//   clr_i       synchronous clear, has priority over shift
//   shift_en_i  shift bit_i in this cycle
//   bit_i       serial input bit
//   data_o      parallel register contents
// -----------------------------------------------------------------------------
module secure_serdes_shift_in
  import secure_serdes_pkg::*;
#(
  parameter int WIDTH = FRAME_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (shift_en_i) begin
      data_d = {data_q[WIDTH-2:0], bit_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/secure_serdes_decryptor.sv
// -----------------------------------------------------------------------------
// secure_serdes_decryptor
// Receive side of the secure SerDes link. Deserializes an 8-bit MSB-first
// cipher stream and the bit-aligned pad stream, then recovers
// plain = C ^ B ^ key_byte into a valid/ready holding register.
// Optional feature macro: SECURE_SERDES_ROLLING_KEY_EN
//   defined   : key byte rotates through KEY bytes 0..15, one step per frame
//   undefined : key byte is always KEY[7:0]
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   start        frame start strobe, sampled only in IDLE
//   cipher_bit   serial cipher data, MSB first
//   b_bit        serial pad data, MSB first
//   plain_ready  consumer accepts plain_data when high with plain_valid
//   plain_data   recovered plaintext byte
//   plain_valid  holding register full
//   busy         high in RECV and DECRYPT
//   overrun      sticky: a completed frame was dropped (register full)
// -----------------------------------------------------------------------------
module secure_serdes_decryptor
  import secure_serdes_pkg::*;
#(
  parameter logic [127:0] KEY = DEFAULT_KEY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cipher_bit,
  input  logic       b_bit,
  input  logic       plain_ready,
  output logic [7:0] plain_data,
  output logic       plain_valid,
  output logic       busy,
  output logic       overrun
);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       overrun_q;

  logic       clr;
  logic       shift_en;
  logic       dec;
  logic [7:0] c_word;
  logic [7:0] b_word;
  logic [7:0] key_byte;
  logic [7:0] result;
  logic       load;
  logic       drain;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RECV;
      RECV:    if (bit_cnt_q == 3'd7) state_d = DECRYPT;
      DECRYPT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    clr      = (state_q == IDLE) && start;
    shift_en = (state_q == RECV);
    dec      = (state_q == DECRYPT);
    busy     = (state_q != IDLE);
  end

  // Bit counter wraps 7 -> 0 naturally on the last RECV cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q <= 3'd0;
    end else if (clr) begin
      bit_cnt_q <= 3'd0;
    end else if (shift_en) begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  secure_serdes_shift_in #(.WIDTH(FRAME_BITS)) u_shift_c (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .shift_en_i (shift_en),
    .bit_i      (cipher_bit),
    .data_o     (c_word)
  );

  secure_serdes_shift_in #(.WIDTH(FRAME_BITS)) u_shift_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .shift_en_i (shift_en),
    .bit_i      (b_bit),
    .data_o     (b_word)
  );

`ifdef SECURE_SERDES_ROLLING_KEY_EN
  logic [3:0] key_idx_q;

  // Advances on every DECRYPT, dropped frames included, to track the transmitter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_idx_q <= 4'd0;
    end else if (dec) begin
      key_idx_q <= key_idx_q + 4'd1;
    end
  end

  assign key_byte = key_byte_at(KEY, key_idx_q);
`else
  assign key_byte = KEY[7:0];
`endif

  assign result = c_word ^ b_word ^ key_byte;

  // A drain in the same cycle frees the slot, so a DECRYPT can still load.
  assign drain = valid_q && plain_ready;
  assign load  = dec && (!valid_q || plain_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= result;
        valid_q <= 1'b1;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
      if (dec && !load) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign plain_data  = data_q;
  assign plain_valid = valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_secure_serdes_decryptor.sv
// -----------------------------------------------------------------------------
// tb_secure_serdes_decryptor
// Scoreboard bench: the driver chooses a plaintext and pad, encrypts it with
// the link key, streams it, and pushes the plaintext into a queue when the
// holding register should accept it. A monitor on the falling edge compares
// outputs against the model and pops on each valid/ready handshake.
// -----------------------------------------------------------------------------
module tb_secure_serdes_decryptor;

  localparam logic [127:0] TB_KEY = 128'hA1B2_C3D4_E5F6_0123_4567_89AB_CDEF_1234;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cipher_bit;
  logic       b_bit;
  logic       plain_ready;
  logic [7:0] plain_data;
  logic       plain_valid;
  logic       busy;
  logic       overrun;

  secure_serdes_decryptor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cipher_bit  (cipher_bit),
    .b_bit       (b_bit),
    .plain_ready (plain_ready),
    .plain_data  (plain_data),
    .plain_valid (plain_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Model state
  logic [7:0] exp_q[$];
  bit         m_full;
  bit         m_ovr;
  bit         m_busy;
  bit         m_zero;
  int         m_idx;
  logic [7:0] m_pending;
  bit         mon_en;
  int         policy;   // 0: ready low, 1: ready high, 2: random, 3: high only on DECRYPT

  int checks;
  int errors;

  function automatic logic [7:0] key_at(input int idx);
    logic [127:0] k;
    k = TB_KEY;
`ifdef SECURE_SERDES_ROLLING_KEY_EN
    return k[8*(idx % 16) +: 8];
`else
    return k[7:0];
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("valid", {7'd0, plain_valid}, {7'd0, m_full});
        chk("busy", {7'd0, busy}, {7'd0, m_busy});
        chk("overrun", {7'd0, overrun}, {7'd0, m_ovr});
        if (plain_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL data_unexpected at %0t: got %02h expected no valid byte", $time, plain_data);
          end else begin
            chk("data", plain_data, exp_q[0]);
            if (plain_ready) void'(exp_q.pop_front());
          end
        end else if (m_zero) begin
          chk("rst_data", plain_data, 8'h00);
        end
      end
    end
  end

  // One clock edge; the model consumes the inputs sampled at that edge.
  task automatic tick(input bit is_dec, input bit is_start);
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_full = 0; m_ovr = 0; m_busy = 0; m_zero = 1; m_idx = 0;
    end else begin
      if (is_dec) begin
        if (!m_full || plain_ready) begin
          exp_q.push_back(m_pending);
          m_full = 1;
          m_zero = 0;
        end else begin
          m_ovr = 1;
        end
        m_idx++;
        m_busy = 0;
      end else if (m_full && plain_ready) begin
        m_full = 0;
      end
      if (is_start) m_busy = 1;
    end
    #1;
  endtask

  task automatic drive_ready(input bit is_dec);
    case (policy)
      0: plain_ready = 1'b0;
      1: plain_ready = 1'b1;
      2: plain_ready = 1'($urandom_range(0, 1));
      default: plain_ready = is_dec;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      cipher_bit = 1'($urandom_range(0, 1));
      b_bit = 1'($urandom_range(0, 1));
      drive_ready(1'b0);
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic send_raw(input logic [7:0] c, input logic [7:0] b);
    m_pending = c ^ b ^ key_at(m_idx);
    start = 1'b1;
    cipher_bit = 1'($urandom_range(0, 1));
    b_bit = 1'($urandom_range(0, 1));
    drive_ready(1'b0);
    tick(1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      start = 1'($urandom_range(0, 1));   // must be ignored while receiving
      cipher_bit = c[i];
      b_bit = b[i];
      drive_ready(1'b0);
      tick(1'b0, 1'b0);
    end
    start = 1'($urandom_range(0, 1));
    drive_ready(1'b1);
    tick(1'b1, 1'b0);
    start = 1'b0;
  endtask

  task automatic send_plain(input logic [7:0] p, input logic [7:0] b);
    send_raw(p ^ b ^ key_at(m_idx), b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; mon_en = 0;
    m_full = 0; m_ovr = 0; m_busy = 0; m_zero = 1; m_idx = 0; m_pending = 8'h00;
    policy = 1;
    rst_n = 1'b0; start = 1'b0; cipher_bit = 1'b0; b_bit = 1'b0; plain_ready = 1'b0;
    tick(1'b0, 1'b0);
    mon_en = 1;
    tick(1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame: C=0x52, B=0x3C -> 0x5A (default key byte 0x34)
    policy = 1;
    send_plain(8'h5A, 8'h3C);
    idle(3);

    // Back-pressure: second frame dropped, overrun sticky after draining
    policy = 0;
    send_plain(8'h5A, 8'h3C);
    send_plain(8'h11, 8'h3C);
    idle(2);
    policy = 1;
    idle(3);

    // Simultaneous drain and load on the second frame's DECRYPT
    do_reset();
    policy = 0;
    send_plain(8'hA5, 8'h0F);
    policy = 3;
    send_plain(8'h3E, 8'hC1);
    policy = 1;
    idle(3);

    // All-ones streams with random start pulses during RECV
    send_raw(8'hFF, 8'hFF);
    idle(2);

    // Reset in the middle of RECV, then a clean frame
    start = 1'b1; cipher_bit = 1'b1; b_bit = 1'b0; drive_ready(1'b0);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b0; cipher_bit = 1'($urandom_range(0, 1)); b_bit = 1'($urandom_range(0, 1));
      tick(1'b0, 1'b0);
    end
    do_reset();
    idle(1);
    send_plain(8'hC3, 8'h69);
    idle(2);

    // Zero streams: exposes the key byte sequence (and its wrap after 16 frames)
    do_reset();
    for (int f = 0; f < 18; f++) send_raw(8'h00, 8'h00);
    idle(2);

    // Randomized frames, ready policies and occasional resets
    for (int f = 0; f < 40; f++) begin
      policy = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) do_reset();
      send_plain(8'($urandom), 8'($urandom));
      idle($urandom_range(0, 2));
    end

    policy = 1;
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_empty: %0d bytes never delivered, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
